fetch_stage_ctrl: RTL and testbench
===================================

# fetch_stage_ctrl

Instruction-fetch stage for the five-stage MIPS pipeline: owns the PC, issues instruction-memory requests, and drives the IF/ID pipeline register. It is the consumer of the hazard unit's hold outputs and of the EX-stage jump/branch redirect. It honours PC/IF-ID holds, flushes IF/ID on redirect, and absorbs variable instruction-memory latency through a one-entry skid buffer.

## Interface
Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- pc_hold  in  1  hazard unit PCWrite; 1 = do not advance PC
- if_id_hold  in  1  hazard unit IF_ID_Write; 1 = do not load IF/ID
- redirect_valid  in  1  taken jump/branch from EX; 1 = refetch from redirect_pc
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address, word-aligned
- imem_rdy  in  1  memory response valid; qualifies imem_rdata
- imem_rdata  in  INSTR_W  fetched instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  ADDR_W  address of the instruction in IF/ID
- if_id_pc4  out  ADDR_W  if_id_pc + 4
- if_id_instr  out  INSTR_W  instruction in IF/ID; NOP (32'h0) when invalid
- fetch_stall  out  1  1 while IF/ID cannot be refilled this cycle (waiting on memory or holding)

## Operation
- stall = pc_hold | if_id_hold. Priority: reset > redirect_valid > stall > normal.
- FSM states: FETCH, HOLD, DROP.
- FETCH: imem_req=1, imem_addr=pc. On imem_rdy with no stall and no redirect: IF/ID <= {valid=1, pc, pc+4, rdata}; pc <= pc+4; stay in FETCH. On imem_rdy with stall: capture rdata in the skid buffer, go to HOLD, and leave the PC unchanged. Without imem_rdy: if_id_valid <= 0 unless if_id_hold, in which case IF/ID keeps its value.
- HOLD: imem_req=0. IF/ID is unchanged while stall=1. When stall=0: IF/ID <= skid, pc <= pc+4, go to FETCH.
- imem_addr stays stable while imem_req=1 and imem_rdy=0; the memory depends on this.
- Redirect in FETCH with no imem_rdy this cycle: latch redirect_pc into pend_pc and go to DROP. If imem_rdy arrives in the same cycle, discard the data, set pc <= redirect_pc, and stay in FETCH.
- Redirect in HOLD: discard the skid, set pc <= redirect_pc, go to FETCH.
- DROP: imem_req=1 with the old address. On imem_rdy, discard the data, set pc <= pend_pc, go to FETCH. A second redirect while in DROP overwrites pend_pc.
- Any redirect: if_id_valid <= 0 and if_id_instr <= NOP next edge, regardless of if_id_hold.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0 with no error.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=0, fetch_stall=1.
- imem_req rises in the first cycle after rst_n deasserts.
- Zero-wait memory (imem_rdy held 1): one instruction per cycle; rdy in cycle N appears in IF/ID after edge N.
- Redirect penalty: redirect in cycle N gives IF/ID invalid after edge N. The target is requested in cycle N+1 (FETCH) or after the outstanding response returns (DROP).
- Stall release: the skid contents enter IF/ID on the first edge with stall=0, with no extra bubble.
- rst_n assertion mid-transaction: the outstanding request is abandoned, outputs go to reset values asynchronously, and the memory must tolerate a dropped request.

## Structure
- fetch_pkg holds the state enum (FETCH/HOLD/DROP), the NOP constant, and the PC_INC=4 constant.
- One sub-module, if_id_reg: load, flush, and hold of {valid, pc, pc4, instr}, with flush priority over hold. PC, skid buffer, and FSM stay in the top module.

## Test plan
- Reset then zero-wait memory, RESET_PC=0: imem_addr sequence 0,4,8,C; IF/ID pc follows one cycle behind, if_id_pc4 = pc+4.
- imem_rdy delayed 3 cycles at addr 0x10: imem_addr stays 0x10 for all cycles, if_id_valid=0 meanwhile, IF/ID loads 0x10 after rdy.
- Load-use hold (pc_hold=if_id_hold=1 for 2 cycles) while rdy arrives for 0x20: IF/ID keeps the prior instruction, state HOLD, imem_req=0; the 0x20 instruction loads on the first unheld edge, then the fetch of 0x24 starts.
- Redirect to 0x100 while a 0x40 request is outstanding: state DROP, the 0x40 data is discarded, the next imem_addr is 0x100, and IF/ID never shows 0x40.
- Redirect together with if_id_hold=1 (jump case): IF/ID is flushed (valid=0, instr=0) next edge and the fetch resumes at the target.
- Wrap: pc=32'hFFFF_FFFC fetched, so the next imem_addr is 0. Also assert rst_n mid-wait and check that all outputs immediately take their reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0]  NOP    = 32'h0000_0000;
  localparam int unsigned  PC_INC = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, idle inserts a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               hold_i,
  input  logic               load_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc4_o,
  output logic [INSTR_W-1:0] instr_o
);

  // Register update; pc/pc4 are left alone on flush/bubble since valid qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      pc4_o   <= '0;
      instr_o <= INSTR_W'(NOP);
    end else if (flush_i) begin
      valid_o <= 1'b0;
      instr_o <= INSTR_W'(NOP);
    end else if (hold_i) begin
      valid_o <= valid_o;
    end else if (load_i) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      pc4_o   <= pc4_i;
      instr_o <= instr_i;
    end else begin
      valid_o <= 1'b0;
      instr_o <= INSTR_W'(NOP);
    end
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage: PC, imem request, skid buffer and IF/ID control.
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_hold,
  input  logic               if_id_hold,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               fetch_stall
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pend_q, pend_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic               req_q, req_d;
  logic               stall_q, stall_d;

  logic               stall;
  logic               rdy;
  logic [ADDR_W-1:0]  redir_pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic               ifid_load;
  logic               ifid_hold;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_instr;

  assign stall    = pc_hold | if_id_hold;
  // A response only counts while a request is actually being presented.
  assign rdy      = imem_rdy & req_q;
  assign redir_pc = redirect_pc & ~ADDR_W'(3);
  assign pc_inc   = pc_q + ADDR_W'(PC_INC);

  // Next-state, PC, skid and IF/ID control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    skid_d     = skid_q;
    ifid_load  = 1'b0;
    ifid_hold  = if_id_hold;
    ifid_flush = redirect_valid;
    ifid_instr = imem_rdata;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (rdy) begin
            pc_d = redir_pc;
          end else begin
            pend_d  = redir_pc;
            state_d = DROP;
          end
        end else if (rdy) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_inc;
          end
        end
      end
      HOLD: begin
        ifid_hold  = stall;
        ifid_instr = skid_q;
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_inc;
          state_d   = FETCH;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pend_d = redir_pc;
        end
        if (rdy) begin
          pc_d    = redirect_valid ? redir_pc : pend_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    req_d   = (state_d != HOLD);
    stall_d = ~ifid_load;
  end

  // State and registered request/stall outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      skid_q  <= INSTR_W'(NOP);
      req_q   <= 1'b0;
      stall_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
      stall_q <= stall_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign fetch_stall = stall_q;

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (ifid_flush),
    .hold_i  (ifid_hold),
    .load_i  (ifid_load),
    .pc_i    (pc_q),
    .pc4_i   (pc_inc),
    .instr_i (ifid_instr),
    .valid_o (if_id_valid),
    .pc_o    (if_id_pc),
    .pc4_o   (if_id_pc4),
    .instr_o (if_id_instr)
  );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl with a queue-based IF/ID scoreboard.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_hold, if_id_hold, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        fetch_stall;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdy       (imem_rdy),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_instr    (if_id_instr),
    .fetch_stall    (fetch_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each fresh IF/ID load must match the oldest expected fetch.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fetch_stall === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h with empty queue", if_id_pc);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_valid", 32'(if_id_valid), 32'd1);
        chk("sb_pc",    if_id_pc,    e);
        chk("sb_pc4",   if_id_pc4,   e + 32'd4);
        chk("sb_instr", if_id_instr, mem_word(e));
      end
    end
  end

  task automatic step(input logic rdy, input logic ph, input logic ih,
                      input logic rv, input logic [31:0] rpc);
    imem_rdy       = rdy;
    pc_hold        = ph;
    if_id_hold     = ih;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(imem_req),    32'd0);
    chk({tag, "_addr"},  imem_addr,        32'd0);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, "_pc"},    if_id_pc,         32'd0);
    chk({tag, "_pc4"},   if_id_pc4,        32'd0);
    chk({tag, "_instr"}, if_id_instr,      32'd0);
    chk({tag, "_stall"}, 32'(fetch_stall), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    imem_rdy = 1'b0; pc_hold = 1'b0; if_id_hold = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");

    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("req_rise", 32'(imem_req), 32'd1);
    chk("addr_0",   imem_addr,     32'h0);

    // Zero-wait memory: 0,4,8,C one per cycle
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(32'(i * 4));
      step(1, 0, 0, 0, 0);
      chk("zw_addr", imem_addr, 32'(i * 4 + 4));
    end

    // Three-cycle memory wait at 0x10
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("wait_addr",  imem_addr,        32'h10);
      chk("wait_valid", 32'(if_id_valid), 32'd0);
      chk("wait_req",   32'(imem_req),    32'd1);
    end
    sb_q.push_back(32'h10);
    step(1, 0, 0, 0, 0);
    chk("after_wait_addr", imem_addr, 32'h14);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(32'(32'h14 + i * 4));
      step(1, 0, 0, 0, 0);
    end
    chk("pre_hold_addr", imem_addr, 32'h20);

    // Load-use hold while 0x20 returns
    step(1, 1, 1, 0, 0);
    chk("hold1_req",   32'(imem_req),    32'd0);
    chk("hold1_pc",    if_id_pc,         32'h1C);
    chk("hold1_valid", 32'(if_id_valid), 32'd1);
    step(0, 1, 1, 0, 0);
    chk("hold2_req",   32'(imem_req),    32'd0);
    chk("hold2_pc",    if_id_pc,         32'h1C);
    sb_q.push_back(32'h20);
    step(0, 0, 0, 0, 0);
    chk("release_req",  32'(imem_req), 32'd1);
    chk("release_addr", imem_addr,     32'h24);
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(32'(32'h24 + i * 4));
      step(1, 0, 0, 0, 0);
    end
    chk("pre_drop_addr", imem_addr, 32'h40);

    // Redirect to 0x100 with 0x40 outstanding
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h100);
    chk("drop_valid", 32'(if_id_valid), 32'd0);
    chk("drop_instr", if_id_instr,      32'd0);
    chk("drop_addr",  imem_addr,        32'h40);
    chk("drop_req",   32'(imem_req),    32'd1);
    step(0, 0, 0, 0, 0);
    chk("drop_addr2", imem_addr, 32'h40);
    step(1, 0, 0, 0, 0);
    chk("drop_done_addr",  imem_addr,        32'h100);
    chk("drop_done_valid", 32'(if_id_valid), 32'd0);
    sb_q.push_back(32'h100);
    step(1, 0, 0, 0, 0);
    chk("tgt_next_addr", imem_addr, 32'h104);

    // Jump: redirect with if_id_hold, low address bits ignored
    step(1, 0, 1, 1, 32'h203);
    chk("jmp_valid", 32'(if_id_valid), 32'd0);
    chk("jmp_instr", if_id_instr,      32'd0);
    chk("jmp_addr",  imem_addr,        32'h200);
    sb_q.push_back(32'h200);
    step(1, 0, 0, 0, 0);

    // PC wrap at top of address space
    step(1, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    sb_q.push_back(32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    chk("wrap_addr_zero", imem_addr, 32'h0);

    // Asynchronous reset in the middle of a wait
    step(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
